xor_net_scheduler: RTL and testbench

- Shares one 3-input XOR inference network (4 hidden neurons, registered output layer, Q8.8 operands) between NUM_REQ requesters.
- Round-robin arbitration; latches the winner's operands and holds them stable on the network inputs.
- Waits out the network pipeline latency, captures the thresholded result, and returns it tagged with the requester ID over a valid/ready response channel.
- Sits between the host-side request sources and the network instance.

---
 rtl/xor_net_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/xor_net_scheduler.sv | 116 +++++++++++
 tb/tb_xor_net_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_net_pkg.sv
// Shared types and constants for the XOR network scheduler: Q8.8 encodings,
// scheduler state encoding and the default network pipeline depth.
package xor_net_pkg;

   localparam logic [15:0] ONE  = 16'h0100;
   localparam logic [15:0] HALF = 16'h0080;
   localparam logic [15:0] ZERO = 16'h0000;

   localparam int DEF_NET_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } sched_state_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
   } operands_t;

   // The network only ever returns ONE or ZERO; anything nonzero reads as a 1.
   function automatic logic q88_nonzero(input logic [15:0] v);
      return v != ZERO;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping modulo N; zero latency, no storage, no backpressure of its own.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [IDX_W-1:0] k;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
         k = IDX_W'((int'(ptr) + i) % N);
         if (!found && req[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/xor_net_scheduler.sv
// Time-shares one XOR inference network among NUM_REQ requesters; response valid
// NET_LATENCY+1 edges after accept, held until rsp_ready, one request in flight.
module xor_net_scheduler
   import xor_net_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int NET_LATENCY = DEF_NET_LATENCY,
   parameter int CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*16-1:0]   req_a,
   input  logic [NUM_REQ*16-1:0]   req_b,
   input  logic [NUM_REQ*16-1:0]   req_c,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic signed [15:0]      net_a,
   output logic signed [15:0]      net_b,
   output logic signed [15:0]      net_c,
   input  logic [15:0]             net_result,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [15:0]             rsp_data,
   output logic                    rsp_bit,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    busy,
   output logic [CNT_W-1:0]        done_count
);

   localparam int WC_W = $clog2(NET_LATENCY + 2);

   sched_state_t        state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]  grant;
   logic                any_req;
   logic [WC_W-1:0]     wait_cnt;
   operands_t           win_ops;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .found (any_req)
   );

   // Gated by rst so the ready lines drop the moment reset is applied.
   assign req_ready = (state == IDLE && !rst) ? grant : '0;
   assign busy      = (state != IDLE);

   always_comb begin
      win_ops = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_ops.a = req_a[i*16 +: 16];
            win_ops.b = req_b[i*16 +: 16];
            win_ops.c = req_c[i*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         wait_cnt   <= '0;
         net_a      <= '0;
         net_b      <= '0;
         net_c      <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_bit    <= 1'b0;
         rsp_id     <= '0;
         done_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  net_a    <= win_ops.a;
                  net_b    <= win_ops.b;
                  net_c    <= win_ops.c;
                  rsp_id   <= win_idx;
                  rr_ptr   <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                  wait_cnt <= WC_W'(NET_LATENCY);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // One extra edge beyond the pipeline depth so the result register has settled.
               if (wait_cnt == '0) begin
                  rsp_data  <= net_result;
                  rsp_bit   <= q88_nonzero(net_result);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  done_count <= done_count + 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_net_scheduler.sv
// Directed bench for xor_net_scheduler with a behavioural 2-stage XOR network model.
module tb_xor_net_scheduler;

   logic        clk;
   logic        rst;

   logic [1:0]  req_valid;
   logic [31:0] req_a, req_b, req_c;
   logic [1:0]  req_ready;
   logic [15:0] net_a, net_b, net_c, net_result, n1;
   logic        rsp_valid, rsp_ready, rsp_bit, busy;
   logic [15:0] rsp_data;
   logic [0:0]  rsp_id;
   logic [15:0] done_count;

   logic [2:0]  req_valid3;
   logic [47:0] req_a3, req_b3, req_c3;
   logic [2:0]  req_ready3;
   logic [15:0] net_a3, net_b3, net_c3, net_result3, n1_3;
   logic        rsp_valid3, rsp_ready3, rsp_bit3, busy3;
   logic [15:0] rsp_data3;
   logic [1:0]  rsp_id3;
   logic [3:0]  done_count3;

   int checks = 0;
   int errors = 0;

   xor_net_scheduler #(.NUM_REQ(2), .ID_W(1), .NET_LATENCY(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_c(req_c), .req_ready(req_ready), .net_a(net_a), .net_b(net_b), .net_c(net_c),
      .net_result(net_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_bit(rsp_bit), .rsp_id(rsp_id), .busy(busy),
      .done_count(done_count)
   );

   xor_net_scheduler #(.NUM_REQ(3), .ID_W(2), .NET_LATENCY(2), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
      .req_c(req_c3), .req_ready(req_ready3), .net_a(net_a3), .net_b(net_b3), .net_c(net_c3),
      .net_result(net_result3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_data(rsp_data3), .rsp_bit(rsp_bit3), .rsp_id(rsp_id3), .busy(busy3),
      .done_count(done_count3)
   );

   function automatic logic [15:0] net_eval(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
      logic x;
      x = ($signed(a) >= 16'sh0080) ^ ($signed(b) >= 16'sh0080) ^ ($signed(c) >= 16'sh0080);
      return x ? 16'h0100 : 16'h0000;
   endfunction

   always_ff @(posedge clk) begin
      n1          <= net_eval(net_a, net_b, net_c);
      net_result  <= n1;
      n1_3        <= net_eval(net_a3, net_b3, net_c3);
      net_result3 <= n1_3;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      req_valid3 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 30 && busy; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_drain busy=%b want 0", name, busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b want 00", req_ready); end
      checks++;
      if ({net_a, net_b, net_c} !== 48'h0) begin errors++; $display("FAIL reset_net got=%h want 0", {net_a, net_b, net_c}); end
      checks++;
      if ({rsp_valid, rsp_bit, rsp_id, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b want 0000", {rsp_valid, rsp_bit, rsp_id, busy}); end
      checks++;
      if ({rsp_data, done_count} !== 32'h0) begin errors++; $display("FAIL reset_data_cnt got=%h want 0", {rsp_data, done_count}); end
      req_valid = 2'b00;
      rst = 1'b0;
   endtask

   task automatic test_single();
      int lat;
      lat = 0;
      do_reset();
      rsp_ready = 1'b1;
      req_a = {16'h0000, 16'h0100}; req_b = '0; req_c = '0;
      req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got=%b want 01", req_ready); end
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1 || net_a !== 16'h0100) begin
         errors++; $display("FAIL single_after_accept ready=%b busy=%b net_a=%h want 00/1/0100", req_ready, busy, net_a);
      end
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin lat = k; break; end
      end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL single_latency got=%0d want 3", lat); end
      checks++;
      if (rsp_data !== 16'h0100 || rsp_bit !== 1'b1 || rsp_id !== 1'b0) begin
         errors++; $display("FAIL single_rsp data=%h bit=%b id=%0d want 0100/1/0", rsp_data, rsp_bit, rsp_id);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || done_count !== 16'd1 || busy !== 1'b0) begin
         errors++; $display("FAIL single_done valid=%b cnt=%0d busy=%b want 0/1/0", rsp_valid, done_count, busy);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (net_a !== 16'h0100) begin errors++; $display("FAIL single_net_hold got=%h want 0100", net_a); end
   endtask

   task automatic test_simultaneous();
      logic [1:0]  g[4];
      int          gt[4];
      logic [0:0]  rid[2];
      logic [15:0] rd[2];
      int ng, nr;
      ng = 0; nr = 0;
      do_reset();
      rsp_ready = 1'b1;
      req_a = {16'h0000, 16'h0100}; req_b = {16'h0000, 16'h0100}; req_c = '0;
      req_valid = 2'b11;
      #1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (req_ready != 2'b00 && ng < 4) begin g[ng] = req_ready; gt[ng] = cyc; ng++; end
         if (rsp_valid && nr < 2) begin rid[nr] = rsp_id; rd[nr] = rsp_data; nr++; end
         if (ng == 4 && nr == 2) break;
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      checks++;
      if (ng != 4 || nr != 2) begin errors++; $display("FAIL sim_counts grants=%0d rsps=%0d want 4/2", ng, nr); end
      else begin
         checks++;
         if ({g[0], g[1], g[2], g[3]} !== 8'b01_10_01_10) begin
            errors++; $display("FAIL sim_grant_order got=%b %b %b %b want 01 10 01 10", g[0], g[1], g[2], g[3]);
         end
         checks++;
         if (gt[1] - gt[0] != 5 || gt[2] - gt[1] != 5) begin
            errors++; $display("FAIL sim_throughput gaps=%0d,%0d want 5,5", gt[1] - gt[0], gt[2] - gt[1]);
         end
         checks++;
         if (rid[0] !== 1'b0 || rid[1] !== 1'b1 || rd[0] !== 16'h0000 || rd[1] !== 16'h0000) begin
            errors++; $display("FAIL sim_rsp ids=%0d,%0d data=%h,%h want 0,1 0000,0000", rid[0], rid[1], rd[0], rd[1]);
         end
      end
      wait_idle("sim");
   endtask

   task automatic test_backpressure();
      logic stable_ok;
      stable_ok = 1'b1;
      do_reset();
      rsp_ready = 1'b0;
      req_a = {16'h0100, 16'h0000}; req_b = '0; req_c = '0;
      req_valid = 2'b10;
      @(posedge clk); #1;
      req_valid = 2'b01;
      for (int k = 0; k < 20 && !rsp_valid; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid got=%b want 1", rsp_valid); end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_data !== 16'h0100 || rsp_id !== 1'b1 || rsp_bit !== 1'b1
             || req_ready !== 2'b00 || busy !== 1'b1) stable_ok = 1'b0;
      end
      checks++;
      if (stable_ok !== 1'b1) begin
         errors++; $display("FAIL bp_hold valid=%b data=%h id=%0d ready=%b busy=%b want 1/0100/1/00/1", rsp_valid, rsp_data, rsp_id, req_ready, busy);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || done_count !== 16'd1) begin
         errors++; $display("FAIL bp_release valid=%b cnt=%0d want 0/1", rsp_valid, done_count);
      end
      rsp_ready = 1'b1;
      repeat (4) @(posedge clk); #1;
      checks++;
      if (done_count !== 16'd1) begin errors++; $display("FAIL bp_single_handshake cnt=%0d want 1", done_count); end
   endtask

   task automatic test_reset_mid();
      logic spurious;
      int lat;
      spurious = 1'b0; lat = 0;
      do_reset();
      rsp_ready = 1'b1;
      req_a = {16'h0000, 16'h0100}; req_b = '0; req_c = '0;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_idle("mid_first");
      req_a = {16'h0000, 16'h0080}; req_b = {16'h0000, 16'h0080};
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0 || net_a !== 16'h0000 || req_ready !== 2'b00) begin
         errors++; $display("FAIL mid_reset valid=%b busy=%b cnt=%0d net_a=%h want 0/0/0/0000", rsp_valid, busy, done_count, net_a);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) spurious = 1'b1;
      end
      checks++;
      if (spurious !== 1'b0) begin errors++; $display("FAIL mid_no_rsp saw rsp_valid=1 want none"); end
      req_a = {16'h0100, 16'h0000}; req_b = {16'h0100, 16'h0000}; req_c = {16'h0100, 16'h0000};
      req_valid = 2'b10;
      @(posedge clk); #1;
      req_valid = 2'b00;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin lat = k; break; end
      end
      checks++;
      if (lat != 3 || rsp_data !== 16'h0100 || rsp_id !== 1'b1) begin
         errors++; $display("FAIL mid_recover lat=%0d data=%h id=%0d want 3/0100/1", lat, rsp_data, rsp_id);
      end
      @(posedge clk); #1;
      checks++;
      if (done_count !== 16'd1) begin errors++; $display("FAIL mid_count got=%0d want 1", done_count); end
   endtask

   task automatic test_rr_wrap();
      do_reset();
      rsp_ready3 = 1'b1;
      req_a3 = '0; req_b3 = '0; req_c3 = '0;
      req_valid3 = 3'b100;
      #1;
      checks++;
      if (req_ready3 !== 3'b100) begin errors++; $display("FAIL wrap_first got=%b want 100", req_ready3); end
      @(posedge clk); #1;
      req_valid3 = 3'b111;
      for (int k = 0; k < 30 && busy3; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (busy3 !== 1'b0 || req_ready3 !== 3'b001) begin
         errors++; $display("FAIL wrap_to_zero busy=%b grant=%b want 0/001", busy3, req_ready3);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 30 && busy3; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (req_ready3 !== 3'b010) begin errors++; $display("FAIL wrap_next got=%b want 010", req_ready3); end
      req_valid3 = 3'b000;
      for (int k = 0; k < 30 && busy3; k++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_count_wrap();
      int nh;
      nh = 0;
      do_reset();
      rsp_ready3 = 1'b1;
      req_valid3 = 3'b001;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(posedge clk); #1;
         if (rsp_valid3) begin
            nh++;
            if (nh == 16) begin
               req_valid3 = 3'b000;
               checks++;
               if (done_count3 !== 4'd15) begin errors++; $display("FAIL cnt_pre_wrap got=%0d want 15", done_count3); end
               break;
            end
         end
      end
      @(posedge clk); #1;
      checks++;
      if (nh != 16 || done_count3 !== 4'd0 || rsp_valid3 !== 1'b0) begin
         errors++; $display("FAIL cnt_wrap rsps=%0d cnt=%0d valid=%b want 16/0/0", nh, done_count3, rsp_valid3);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_c = '0; rsp_ready = 1'b0;
      req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_c3 = '0; rsp_ready3 = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_reset_mid();
      test_rr_wrap();
      test_count_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule
